multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with ready handshake, illegal trap and retire counter.
module multicycle_control_unit #(
    parameter int ALUOP_W         = 3,
    parameter int CNT_W           = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               sgn_zero,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_NOR = 3'b101,
                           ALU_SLT = 3'b110, ALU_SLTU = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW  = 6'b101011,
                           OP_BEQ   = 6'b000100, OP_BNE = 6'b000101;

    state_t     state;
    logic [2:0] r_code;
    logic       r_valid;
    logic [2:0] i_code;
    logic       i_valid;
    logic       i_zext;
    logic [2:0] alu_code;

    always_comb begin
        r_code  = ALU_ADD;
        r_valid = 1'b1;
        case (funct)
            6'b100000, 6'b100001: r_code = ALU_ADD;
            6'b100010, 6'b100011: r_code = ALU_SUB;
            6'b100100:            r_code = ALU_AND;
            6'b100101:            r_code = ALU_OR;
            6'b100110:            r_code = ALU_XOR;
            6'b100111:            r_code = ALU_NOR;
            6'b101010:            r_code = ALU_SLT;
            6'b101011:            r_code = ALU_SLTU;
            default:              r_valid = 1'b0;
        endcase
    end

    // Logical immediates are zero-extended; arithmetic and compares sign-extend.
    always_comb begin
        i_code  = ALU_ADD;
        i_valid = 1'b1;
        i_zext  = 1'b0;
        case (op)
            6'b001000, 6'b001001: i_code = ALU_ADD;
            6'b001010:            i_code = ALU_SLT;
            6'b001011:            i_code = ALU_SLTU;
            6'b001100: begin i_code = ALU_AND; i_zext = 1'b1; end
            6'b001101: begin i_code = ALU_OR;  i_zext = 1'b1; end
            6'b001110: begin i_code = ALU_XOR; i_zext = 1'b1; end
            default:              i_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (op == OP_RTYPE && r_valid)   state <= EXEC_R;
                    else if (op == OP_LW || op == OP_SW)   state <= MEM_ADDR;
                    else if (op == OP_BEQ || op == OP_BNE) state <= BRANCH;
                    else if (i_valid)                state <= EXEC_I;
                    else if (TRAP_ON_ILLEGAL) begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state   <= FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                EXEC_R, EXEC_I: state <= ALU_WB;
                ALU_WB, MEM_WB, BRANCH: begin
                    state   <= FETCH;
                    retired <= retired + CNT_W'(1);
                end
                MEM_ADDR: state <= (op == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) state <= MEM_WB;
                MEM_WR: begin
                    if (mem_ready) begin
                        state   <= FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Datapath controls decode from the current state and IR fields.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_code   = ALU_ADD;
        sgn_zero   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                sgn_zero  = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_code  = r_code;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_code  = i_code;
                sgn_zero  = !i_zext;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (op == OP_RTYPE);
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                sgn_zero  = 1'b1;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_code  = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = (op == OP_BEQ) ? zero : !zero;
            end
            default: ;
        endcase
    end

    assign alu_op = ALUOP_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a trapping 16-bit-counter instance and a
// NOP-on-illegal instance with 4-bit counter and 4-bit alu_op share the same stimulus.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic sgn_zero, reg_dst, mem_to_reg, reg_write, illegal;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [15:0] retired;

    logic mem_req_n, mem_we_n, iord_n, ir_write_n, pc_write_n, pc_src_n, alu_src_a_n;
    logic sgn_zero_n, reg_dst_n, mem_to_reg_n, reg_write_n, illegal_n;
    logic [1:0] alu_src_b_n;
    logic [3:0] alu_op_n;
    logic [3:0] retired_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALUOP_W(3), .CNT_W(16), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .sgn_zero(sgn_zero), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .retired(retired)
    );

    multicycle_control_unit #(.ALUOP_W(4), .CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_n), .mem_we(mem_we_n), .iord(iord_n), .ir_write(ir_write_n),
        .pc_write(pc_write_n), .pc_src(pc_src_n), .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n),
        .alu_op(alu_op_n), .sgn_zero(sgn_zero_n), .reg_dst(reg_dst_n), .mem_to_reg(mem_to_reg_n),
        .reg_write(reg_write_n), .illegal(illegal_n), .retired(retired_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_req got %b exp 1", mem_req); end
        checks++; if (alu_src_b !== 2'b01) begin errors++; $display("[TB] FAIL reset_alu_src_b got %b exp 01", alu_src_b); end
        checks++; if (ir_write !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got ir_write=%b mem_we=%b exp 0 0", ir_write, mem_we); end
        checks++; if (retired !== 16'd0) begin errors++; $display("[TB] FAIL reset_retired got %0d exp 0", retired); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b exp 0", illegal); end
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++; if (mem_req !== 1'b1 || ir_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_fetch got mem_req=%b ir_write=%b exp 1 0", mem_req, ir_write); end
    endtask

    task automatic test_add();
        op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        #1;
        checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 1'b0) begin errors++; $display("[TB] FAIL add_fetch got ir_write=%b pc_write=%b pc_src=%b exp 1 1 0", ir_write, pc_write, pc_src); end
        step();
        checks++; if (alu_src_b !== 2'b11 || sgn_zero !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL add_decode got alu_src_b=%b sgn_zero=%b mem_req=%b exp 11 1 0", alu_src_b, sgn_zero, mem_req); end
        step();
        checks++; if (alu_op !== 3'b000 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin errors++; $display("[TB] FAIL add_exec got alu_op=%b a=%b b=%b exp 000 1 00", alu_op, alu_src_a, alu_src_b); end
        step();
        checks++; if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin errors++; $display("[TB] FAIL add_wb got reg_write=%b reg_dst=%b mem_to_reg=%b exp 1 1 0", reg_write, reg_dst, mem_to_reg); end
        checks++; if (retired !== 16'd0) begin errors++; $display("[TB] FAIL add_retired_before got %0d exp 0", retired); end
        step();
        mem_ready = 1'b0;
        checks++; if (retired !== 16'd1 || mem_req !== 1'b1) begin errors++; $display("[TB] FAIL add_retired got %0d mem_req=%b exp 1 1", retired, mem_req); end
    endtask

    task automatic test_lw_wait();
        op = 6'b100011; mem_ready = 1'b1;
        step();
        step();
        checks++; if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || sgn_zero !== 1'b1) begin errors++; $display("[TB] FAIL lw_addr got a=%b b=%b sgn_zero=%b exp 1 10 1", alu_src_a, alu_src_b, sgn_zero); end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) mem_ready = 1'b1;
            checks++; if (mem_req !== 1'b1 || iord !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL lw_rd_wait%0d got mem_req=%b iord=%b mem_we=%b exp 1 1 0", i, mem_req, iord, mem_we); end
        end
        step();
        checks++; if (mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_wb got m2r=%b rw=%b rd=%b req=%b exp 1 1 0 0", mem_to_reg, reg_write, reg_dst, mem_req); end
        step();
        mem_ready = 1'b0;
        checks++; if (retired !== 16'd2) begin errors++; $display("[TB] FAIL lw_retired got %0d exp 2", retired); end
    endtask

    task automatic test_sw();
        op = 6'b101011; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || iord !== 1'b1) begin errors++; $display("[TB] FAIL sw_wr got req=%b we=%b iord=%b exp 1 1 1", mem_req, mem_we, iord); end
        step();
        mem_ready = 1'b1;
        checks++; if (mem_we !== 1'b1 || retired !== 16'd2) begin errors++; $display("[TB] FAIL sw_wait got we=%b retired=%0d exp 1 2", mem_we, retired); end
        step();
        mem_ready = 1'b0;
        checks++; if (retired !== 16'd3 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sw_retired got %0d we=%b exp 3 0", retired, mem_we); end
    endtask

    task automatic test_branch();
        op = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
        step();
        step();
        checks++; if (pc_write !== 1'b1 || pc_src !== 1'b1 || alu_op !== 3'b001 || alu_src_a !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken got pw=%b ps=%b op=%b a=%b exp 1 1 001 1", pc_write, pc_src, alu_op, alu_src_a); end
        zero = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL beq_not_taken got pc_write=%b exp 0", pc_write); end
        step();
        checks++; if (retired !== 16'd4) begin errors++; $display("[TB] FAIL beq_retired got %0d exp 4", retired); end
        op = 6'b000101; zero = 1'b1;
        step();
        step();
        checks++; if (pc_write !== 1'b0 || pc_src !== 1'b1) begin errors++; $display("[TB] FAIL bne_zero got pw=%b ps=%b exp 0 1", pc_write, pc_src); end
        step();
        mem_ready = 1'b0;
        zero = 1'b0;
        checks++; if (retired !== 16'd5) begin errors++; $display("[TB] FAIL bne_retired got %0d exp 5", retired); end
    endtask

    task automatic test_itype();
        op = 6'b001100; mem_ready = 1'b1;
        step();
        step();
        checks++; if (sgn_zero !== 1'b0 || alu_op !== 3'b010 || alu_src_b !== 2'b10) begin errors++; $display("[TB] FAIL andi_exec got sz=%b op=%b b=%b exp 0 010 10", sgn_zero, alu_op, alu_src_b); end
        checks++; if (alu_op_n !== 4'b0010) begin errors++; $display("[TB] FAIL andi_alu_op_wide got %b exp 0010", alu_op_n); end
        step();
        checks++; if (reg_write !== 1'b1 || reg_dst !== 1'b0) begin errors++; $display("[TB] FAIL andi_wb got rw=%b rd=%b exp 1 0", reg_write, reg_dst); end
        step();
        op = 6'b001010;
        step();
        step();
        checks++; if (sgn_zero !== 1'b1 || alu_op !== 3'b110) begin errors++; $display("[TB] FAIL slti_exec got sz=%b op=%b exp 1 110", sgn_zero, alu_op); end
        step();
        step();
        mem_ready = 1'b0;
        checks++; if (retired !== 16'd7 || retired_n !== 4'd7) begin errors++; $display("[TB] FAIL itype_retired got %0d/%0d exp 7/7", retired, retired_n); end
    endtask

    task automatic test_reset_mid_write();
        op = 6'b101011; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL midwr_pre got we=%b exp 1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || iord !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midwr_reset got we=%b iord=%b req=%b exp 0 0 1", mem_we, iord, mem_req); end
        checks++; if (retired !== 16'd0 || retired_n !== 4'd0) begin errors++; $display("[TB] FAIL midwr_retired got %0d/%0d exp 0/0", retired, retired_n); end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
        for (int i = 0; i < 60; i++) step();
        checks++; if (retired_n !== 4'd15 || retired !== 16'd15) begin errors++; $display("[TB] FAIL wrap_15 got %0d/%0d exp 15/15", retired_n, retired); end
        for (int i = 0; i < 4; i++) step();
        mem_ready = 1'b0;
        checks++; if (retired_n !== 4'd0) begin errors++; $display("[TB] FAIL wrap_zero got %0d exp 0", retired_n); end
        checks++; if (retired !== 16'd16) begin errors++; $display("[TB] FAIL wrap_wide got %0d exp 16", retired); end
    endtask

    task automatic test_illegal();
        op = 6'b111111; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        checks++; if (illegal !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL trap_enter got illegal=%b req=%b exp 1 0", illegal, mem_req); end
        checks++; if (illegal_n !== 1'b0 || retired_n !== 4'd1 || mem_req_n !== 1'b1) begin errors++; $display("[TB] FAIL nop_illegal got illegal=%b retired=%0d req=%b exp 0 1 1", illegal_n, retired_n, mem_req_n); end
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (illegal !== 1'b1 || mem_req !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL trap_hold%0d got illegal=%b req=%b irw=%b pw=%b rw=%b exp 1 0 0 0 0", i, illegal, mem_req, ir_write, pc_write, reg_write); end
        end
        checks++; if (retired !== 16'd16) begin errors++; $display("[TB] FAIL trap_retired got %0d exp 16", retired); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_branch();
        test_itype();
        test_reset_mid_write();
        test_wrap();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
